// File: rtl/sine_period_analyzer.sv
// Measures period and amplitude of an offset-binary sine stream by detecting
// rising midscale crossings with hysteresis, and flags frequency lock.
module sine_period_analyzer #(
    parameter int DW   = 8,
    parameter int MID  = 128,
    parameter int HYST = 4,
    parameter int PW   = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          sample_valid,
    input  logic [DW-1:0] sample,
    output logic [PW-1:0] period_out,
    output logic [DW-1:0] max_out,
    output logic [DW-1:0] min_out,
    output logic [DW-1:0] pk2pk_out,
    output logic          meas_valid,
    output logic          lock,
    output logic          ovf
);

    typedef enum logic [1:0] {
        S_INIT_LOW  = 2'd0,
        S_INIT_RISE = 2'd1,
        S_HIGH      = 2'd2,
        S_LOW       = 2'd3
    } state_t;

    localparam logic [DW:0]   HI_TH   = (DW+1)'(MID + HYST);
    localparam logic [DW:0]   LO_TH   = (DW+1)'(MID - HYST);
    localparam logic [PW-1:0] CNT_MAX = {PW{1'b1}};
    localparam logic [PW-1:0] CNT_ONE = {{(PW-1){1'b0}}, 1'b1};

    state_t        state_q;
    logic [PW-1:0] cnt_q;
    logic [DW-1:0] cur_min_q;
    logic [DW-1:0] cur_max_q;
    logic [PW-1:0] prev_period_q;
    logic          prev_vld_q;
    logic [PW-1:0] period_q;
    logic [DW-1:0] max_q;
    logic [DW-1:0] min_q;
    logic [DW-1:0] pk2pk_q;
    logic          meas_valid_q;
    logic          lock_q;
    logic          ovf_q;

    logic          is_hi_s;
    logic          is_lo_s;
    logic          crossing_s;
    logic [DW-1:0] min_d;
    logic [DW-1:0] max_d;

    // Threshold decode and running min/max candidates for the current sample
    always_comb begin
        is_hi_s    = ({1'b0, sample} >= HI_TH);
        is_lo_s    = ({1'b0, sample} <  LO_TH);
        crossing_s = (state_q == S_LOW) && is_hi_s;
        if (sample < cur_min_q) begin
            min_d = sample;
        end else begin
            min_d = cur_min_q;
        end
        if (sample > cur_max_q) begin
            max_d = sample;
        end else begin
            max_d = cur_max_q;
        end
    end

    // Crossing FSM, period/amplitude tracking and registered measurement outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_INIT_LOW;
            cnt_q         <= '0;
            cur_min_q     <= '0;
            cur_max_q     <= '0;
            prev_period_q <= '0;
            prev_vld_q    <= 1'b0;
            period_q      <= '0;
            max_q         <= '0;
            min_q         <= '0;
            pk2pk_q       <= '0;
            meas_valid_q  <= 1'b0;
            lock_q        <= 1'b0;
            ovf_q         <= 1'b0;
        end else begin
            meas_valid_q <= 1'b0;
            ovf_q        <= 1'b0;
            if (sample_valid) begin
                case (state_q)
                    S_INIT_LOW: begin
                        if (is_lo_s) begin
                            state_q <= S_INIT_RISE;
                        end
                    end
                    S_INIT_RISE: begin
                        if (is_hi_s) begin
                            cnt_q     <= CNT_ONE;
                            cur_min_q <= sample;
                            cur_max_q <= sample;
                            state_q   <= S_HIGH;
                        end
                    end
                    S_HIGH, S_LOW: begin
                        if (crossing_s) begin
                            period_q      <= cnt_q;
                            min_q         <= cur_min_q;
                            max_q         <= cur_max_q;
                            pk2pk_q       <= cur_max_q - cur_min_q;
                            meas_valid_q  <= 1'b1;
                            lock_q        <= prev_vld_q && (cnt_q == prev_period_q);
                            prev_period_q <= cnt_q;
                            prev_vld_q    <= 1'b1;
                            cnt_q         <= CNT_ONE;
                            cur_min_q     <= sample;
                            cur_max_q     <= sample;
                            state_q       <= S_HIGH;
                        end else if (cnt_q == CNT_MAX) begin
                            // Period too long to measure: drop lock and resynchronise
                            ovf_q      <= 1'b1;
                            lock_q     <= 1'b0;
                            prev_vld_q <= 1'b0;
                            state_q    <= S_INIT_LOW;
                        end else begin
                            cnt_q     <= cnt_q + CNT_ONE;
                            cur_min_q <= min_d;
                            cur_max_q <= max_d;
                            if ((state_q == S_HIGH) && is_lo_s) begin
                                state_q <= S_LOW;
                            end
                        end
                    end
                    default: begin
                        state_q <= S_INIT_LOW;
                    end
                endcase
            end
        end
    end

    assign period_out = period_q;
    assign max_out    = max_q;
    assign min_out    = min_q;
    assign pk2pk_out  = pk2pk_q;
    assign meas_valid = meas_valid_q;
    assign lock       = lock_q;
    assign ovf        = ovf_q;

endmodule

// File: tb/tb_sine_period_analyzer.sv
// Scoreboard bench for sine_period_analyzer: a behavioural model predicts each
// cycle's outputs, which are queued at drive time and compared after the edge.
module tb_sine_period_analyzer;

    localparam int DW   = 8;
    localparam int MID  = 128;
    localparam int HYST = 4;
    localparam int PW   = 8;
    localparam int CMAX = (1 << PW) - 1;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          sample_valid = 1'b0;
    logic [DW-1:0] sample = '0;
    logic [PW-1:0] period_out;
    logic [DW-1:0] max_out, min_out, pk2pk_out;
    logic          meas_valid, lock, ovf;

    sine_period_analyzer #(.DW(DW), .MID(MID), .HYST(HYST), .PW(PW)) dut (
        .clk(clk), .rst(rst), .sample_valid(sample_valid), .sample(sample),
        .period_out(period_out), .max_out(max_out), .min_out(min_out),
        .pk2pk_out(pk2pk_out), .meas_valid(meas_valid), .lock(lock), .ovf(ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit mv; bit ovf; bit lock;
        int per; int mx; int mn; int pk;
    } exp_t;

    exp_t sb_q[$];
    exp_t e;
    int   m_st, m_cnt, m_min, m_max, m_prev;
    bit   m_pv;

    int total = 0;
    int bad   = 0;
    int pub_period[$];
    bit pub_lock[$];
    int n_ovf;
    int ovf_at;
    int n_acc;

    task automatic check_eq(input string tag, input int act, input int exp_v);
        total++;
        if (act != exp_v) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp_v, $time);
        end
    endtask

    task automatic model_reset();
        m_st = 0; m_cnt = 0; m_min = 0; m_max = 0; m_prev = 0; m_pv = 1'b0;
        e = '{mv: 1'b0, ovf: 1'b0, lock: 1'b0, per: 0, mx: 0, mn: 0, pk: 0};
        sb_q.delete();
    endtask

    task automatic model_step(input bit v, input int s);
        bit hi, lo;
        hi = (s >= MID + HYST);
        lo = (s < MID - HYST);
        e.mv = 1'b0; e.ovf = 1'b0;
        if (v) begin
            case (m_st)
                0: if (lo) m_st = 1;
                1: if (hi) begin m_cnt = 1; m_min = s; m_max = s; m_st = 2; end
                default: begin
                    if (m_st == 3 && hi) begin
                        e.mv = 1'b1; e.per = m_cnt; e.mx = m_max; e.mn = m_min;
                        e.pk = m_max - m_min;
                        e.lock = m_pv && (m_cnt == m_prev);
                        m_prev = m_cnt; m_pv = 1'b1;
                        m_cnt = 1; m_min = s; m_max = s; m_st = 2;
                    end else if (m_cnt == CMAX) begin
                        e.ovf = 1'b1; e.lock = 1'b0; m_pv = 1'b0; m_st = 0;
                    end else begin
                        m_cnt++;
                        if (s < m_min) m_min = s;
                        if (s > m_max) m_max = s;
                        if (m_st == 2 && lo) m_st = 3;
                    end
                end
            endcase
        end
    endtask

    task automatic drive(input bit v, input int s);
        exp_t x;
        sample_valid = v;
        sample = DW'(s);
        model_step(v, s);
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        x = sb_q.pop_front();
        if (v) n_acc++;
        check_eq("meas_valid", int'(meas_valid), int'(x.mv));
        check_eq("ovf", int'(ovf), int'(x.ovf));
        check_eq("lock", int'(lock), int'(x.lock));
        check_eq("period_out", int'(period_out), x.per);
        check_eq("max_out", int'(max_out), x.mx);
        check_eq("min_out", int'(min_out), x.mn);
        check_eq("pk2pk_out", int'(pk2pk_out), x.pk);
        if (meas_valid) begin
            pub_period.push_back(int'(period_out));
            pub_lock.push_back(lock);
        end
        if (ovf) begin
            n_ovf++;
            ovf_at = n_acc;
        end
    endtask

    task automatic check_zero(input string tag);
        check_eq({tag, "_period"}, int'(period_out), 0);
        check_eq({tag, "_max"}, int'(max_out), 0);
        check_eq({tag, "_min"}, int'(min_out), 0);
        check_eq({tag, "_pk2pk"}, int'(pk2pk_out), 0);
        check_eq({tag, "_flags"}, int'({meas_valid, lock, ovf}), 0);
    endtask

    task automatic do_reset();
        sample_valid = 1'b0;
        rst = 1'b1;
        model_reset();
        #1;
        check_zero("rst");
        @(posedge clk);
        #3;
        rst = 1'b0;
        pub_period.delete();
        pub_lock.delete();
        n_ovf = 0; ovf_at = 0; n_acc = 0;
    endtask

    // Square wave: each period is `half` samples of 200 then `half` of 50
    task automatic square(input int half, input int periods, input bit gaps);
        for (int p = 0; p < periods; p++) begin
            for (int i = 0; i < 2 * half; i++) begin
                drive(1'b1, (i < half) ? 200 : 50);
                if (gaps) drive(1'b0, $urandom_range(0, 255));
            end
        end
    endtask

    initial begin
        model_reset();
        do_reset();

        // Basic square wave: publishes at crossings 2 and 3
        square(10, 4, 1'b0);
        check_eq("sq_npub", pub_period.size(), 2);
        if (pub_period.size() >= 2) begin
            check_eq("sq_first_period", pub_period[0], 20);
            check_eq("sq_first_lock", int'(pub_lock[0]), 0);
            check_eq("sq_second_lock", int'(pub_lock[1]), 1);
        end

        // Same waveform with idle cycles between accepted samples
        do_reset();
        square(10, 4, 1'b1);
        check_eq("gap_npub", pub_period.size(), 2);
        if (pub_period.size() >= 2) begin
            check_eq("gap_period", pub_period[0], 20);
            check_eq("gap_lock", int'(pub_lock[1]), 1);
        end

        // Hysteresis band: nothing should ever publish
        do_reset();
        for (int i = 0; i < 200; i++) drive(1'b1, (i % 2 == 0) ? 126 : 130);
        check_eq("hyst_npub", pub_period.size(), 0);
        square(10, 3, 1'b0);
        check_eq("hyst_then_sq_npub", pub_period.size(), 1);

        // Frequency change from period 20 to 24
        do_reset();
        square(10, 4, 1'b0);
        square(12, 3, 1'b0);
        check_eq("fchg_npub", pub_period.size(), 5);
        if (pub_period.size() >= 5) begin
            check_eq("fchg_p3", pub_period[3], 24);
            check_eq("fchg_l3", int'(pub_lock[3]), 0);
            check_eq("fchg_p4", pub_period[4], 24);
            check_eq("fchg_l4", int'(pub_lock[4]), 1);
        end

        // Overflow: hold high after lock until the counter saturates
        do_reset();
        square(10, 4, 1'b0);
        begin
            int base;
            base = n_acc;
            for (int i = 0; i < 260; i++) drive(1'b1, 200);
            check_eq("ovf_count", n_ovf, 1);
            check_eq("ovf_sample_idx", ovf_at - base, 256);
            check_eq("ovf_lock", int'(lock), 0);
        end
        begin
            int np;
            np = pub_period.size();
            square(10, 3, 1'b0);
            check_eq("ovf_resume_npub", pub_period.size() - np, 1);
            if (pub_period.size() > np) begin
                check_eq("ovf_resume_period", pub_period[np], 20);
                check_eq("ovf_resume_lock", int'(pub_lock[np]), 0);
            end
        end

        // Asynchronous reset in the middle of a low half-period after lock
        do_reset();
        square(10, 4, 1'b0);
        drive(1'b1, 200);
        for (int i = 0; i < 5; i++) drive(1'b1, 50);
        check_eq("pre_rst_lock", int'(lock), 1);
        #2;
        rst = 1'b1;
        #1;
        check_zero("async_rst");
        do_reset();
        square(10, 2, 1'b0);
        check_eq("post_rst_npub", pub_period.size(), 0);
        drive(1'b1, 200);
        check_eq("post_rst_npub2", pub_period.size(), 1);
        check_eq("post_rst_lock", int'(lock), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
